// File: rtl/boreal_ledger_mc.sv
// Multi-channel append-only ledger: round-robin commit into a circular store plus a registered read port.
// Optional feature macro: BOREAL_LEDGER_CHAIN_EN (running rotate-XOR digest of committed entries).
module boreal_ledger_mc #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 32,
  parameter int DEPTH  = 16,
  parameter int WRAP   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_gnt,
  output logic [IDX_W-1:0]         idx,
  output logic                     full,
  input  logic                     rd_sel,
  input  logic [IDX_W-1:0]         rd_addr,
  output logic                     rd_ack,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_err,
  output logic [DATA_W-1:0]        chain
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] IDX_MAX   = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_CH - 1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  idx_next_s;
  logic [IDX_W-1:0]  lo_s;
  logic              full_r;
  logic              full_next_s;
  logic [PTR_W-1:0]  rr_ptr_r;
  logic [PTR_W-1:0]  cand_s [NUM_CH];
  logic [PTR_W-1:0]  gnt_idx_s;
  logic              req_any_s;
  logic              commit_s;
  logic [NUM_CH-1:0] gnt_s;
  logic [DATA_W-1:0] gnt_data_s;
  logic              rd_valid_s;
  logic              rd_ack_r;
  logic              rd_err_r;
  logic [DATA_W-1:0] rd_data_r;

  // Candidate channel order, starting at the round-robin pointer.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_cand
    assign cand_s[g] = PTR_W'((int'(rr_ptr_r) + g) % NUM_CH);
  end

  // Round-robin search; grants are suppressed while full or held in reset.
  always_comb begin
    gnt_idx_s  = {PTR_W{1'b0}};
    req_any_s  = 1'b0;
    gnt_s      = {NUM_CH{1'b0}};
    gnt_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      gnt_idx_s = (!req_any_s && ch_req[cand_s[i]]) ? cand_s[i] : gnt_idx_s;
      req_any_s = req_any_s | ch_req[cand_s[i]];
    end
    commit_s = rst_n && !full_r && req_any_s;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt_s[i]   = commit_s && (gnt_idx_s == PTR_W'(i));
      gnt_data_s = (gnt_idx_s == PTR_W'(i)) ? ch_data[i*DATA_W +: DATA_W] : gnt_data_s;
    end
  end

  // Next index and full flag; the index saturates at all-ones and then blocks commits.
  always_comb begin
    idx_next_s = commit_s ? (idx_r + IDX_W'(1)) : idx_r;
    if (WRAP != 0) begin
      full_next_s = (idx_next_s == IDX_MAX);
    end else begin
      full_next_s = (idx_next_s >= DEPTH_IDX) || (idx_next_s == IDX_MAX);
    end
  end

  // Retained window uses the pre-edge index, so a same-edge commit is not yet readable.
  always_comb begin
    if ((WRAP != 0) && (idx_r > DEPTH_IDX)) begin
      lo_s = idx_r - DEPTH_IDX;
    end else begin
      lo_s = {IDX_W{1'b0}};
    end
    rd_valid_s = (rd_addr >= lo_s) && (rd_addr < idx_r);
  end

  // Index, full flag and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r    <= {IDX_W{1'b0}};
      full_r   <= 1'b0;
      rr_ptr_r <= {PTR_W{1'b0}};
    end else begin
      idx_r  <= idx_next_s;
      full_r <= full_next_s;
      if (commit_s) begin
        rr_ptr_r <= (gnt_idx_s == PTR_LAST) ? {PTR_W{1'b0}} : (gnt_idx_s + PTR_W'(1));
      end
    end
  end

  // Entry store; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_r[idx_r[AW-1:0]] <= gnt_data_s;
    end
  end

  // Registered read response; the store is read before the same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ack_r  <= 1'b0;
      rd_err_r  <= 1'b0;
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_sel) begin
      rd_ack_r  <= 1'b1;
      rd_err_r  <= !rd_valid_s;
      rd_data_r <= rd_valid_s ? mem_r[rd_addr[AW-1:0]] : {DATA_W{1'b0}};
    end else begin
      rd_ack_r <= 1'b0;
    end
  end

`ifdef BOREAL_LEDGER_CHAIN_EN
  logic [DATA_W-1:0] chain_r;

  // Rotate-left-by-one then XOR in each committed entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= {DATA_W{1'b0}};
    end else if (commit_s) begin
      chain_r <= {chain_r[DATA_W-2:0], chain_r[DATA_W-1]} ^ gnt_data_s;
    end
  end

  assign chain = chain_r;
`else
  assign chain = {DATA_W{1'b0}};
`endif

  assign ch_gnt  = gnt_s;
  assign idx     = idx_r;
  assign full    = full_r;
  assign rd_ack  = rd_ack_r;
  assign rd_data = rd_data_r;
  assign rd_err  = rd_err_r;

endmodule
